// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 (MSB first) flash responder. Oversamples SCK/CS#/MOSI in the
//   `clock` domain, decodes READ (0x03) + 24-bit address, prefetches bytes
//   from a synchronous memory port and streams them on MISO with an
//   auto-incrementing address.
//   Optional build macro SPI_FLASH_RESPONDER_JEDEC_EN adds the 0x9F
//   JEDEC-ID command (parameter JEDEC_ID, then 0xFF forever).
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   flash_sck/cs_n/mosi   asynchronous SPI inputs from the initiator
//   flash_miso/_miso_oe   serial data out and pad output enable
//   mem_addr/mem_rd       memory read address and one-cycle read strobe
//   mem_rdata             read data, valid one clock after mem_rd
module spi_flash_responder #(
   parameter int ADDR_WIDTH = 19
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
   , parameter logic [23:0] JEDEC_ID = 24'hEF4015
`endif
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flash_sck,
   input  logic                  flash_cs_n,
   input  logic                  flash_mosi,
   output logic                  flash_miso,
   output logic                  flash_miso_oe,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [7:0]            mem_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DATA   = 3'd3,
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
      ST_ID     = 3'd4,
`endif
      ST_IGNORE = 3'd5
   } state_t;

   // Synchronizers; sck_q[2] is the extra history bit for edge detection.
   logic [2:0] sck_q;
   logic [1:0] cs_q, mosi_q;

   state_t                  state_q, state_d;
   logic [4:0]              cnt_q, cnt_d;
   logic [6:0]              sh_q, sh_d;
   logic [23:0]             addr_q, addr_d;
   logic [7:0]              pbuf_q, pbuf_d;
   logic [7:0]              obuf_q, obuf_d;
   logic                    miso_q, miso_d;
   logic                    rd_q, rd_d;
   logic                    rd_dly_q;
   logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
   logic                    armed_q, armed_d;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
   logic [1:0]              idx_q, idx_d;
   logic [7:0]              id_byte;
`endif

   logic        rise, fall, cs_hi, mosi_s;
   logic [7:0]  cmd_w;
   logic [23:0] addr_sh;

   assign rise    = sck_q[1] & ~sck_q[2];
   assign fall    = ~sck_q[1] & sck_q[2];
   assign cs_hi   = cs_q[1];
   assign mosi_s  = mosi_q[1];
   assign cmd_w   = {sh_q, mosi_s};
   assign addr_sh = {addr_q[22:0], mosi_s};

`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
   always_comb begin
      case (idx_q)
         2'd1:    id_byte = JEDEC_ID[15:8];
         2'd2:    id_byte = JEDEC_ID[7:0];
         default: id_byte = 8'hFF;
      endcase
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      addr_d  = addr_q;
      pbuf_d  = pbuf_q;
      obuf_d  = obuf_q;
      miso_d  = miso_q;
      rd_d    = 1'b0;
      maddr_d = maddr_q;
      // A new transaction needs CS# seen high first (e.g. after a reset).
      armed_d = armed_q | cs_hi;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
      idx_d   = idx_q;
`endif
      // Memory data arrives the cycle after the strobe's registered cycle.
      if (rd_dly_q) begin
         pbuf_d = mem_rdata;
         addr_d = addr_q + 24'd1;
      end
      if (cs_hi) begin
         // CS# dominates any same-cycle SCK edge.
         state_d = ST_IDLE;
         cnt_d   = 5'd0;
         miso_d  = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: if (armed_q) begin
               state_d = ST_CMD;
               cnt_d   = 5'd0;
               armed_d = 1'b0;
            end
            ST_CMD: if (rise) begin
               sh_d  = cmd_w[6:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  cnt_d = 5'd0;
                  if (cmd_w == 8'h03) state_d = ST_ADDR;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
                  else if (cmd_w == 8'h9F) begin
                     state_d = ST_ID;
                     pbuf_d  = JEDEC_ID[23:16];
                     idx_d   = 2'd1;
                  end
`endif
                  else state_d = ST_IGNORE;
               end
            end
            ST_ADDR: if (rise) begin
               addr_d = addr_sh;
               cnt_d  = cnt_q + 5'd1;
               if (cnt_q == 5'd23) begin
                  cnt_d   = 5'd0;
                  rd_d    = 1'b1;
                  maddr_d = addr_sh[ADDR_WIDTH-1:0];
                  state_d = ST_DATA;
               end
            end
            ST_DATA
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
            , ST_ID
`endif
            : if (fall) begin
               cnt_d = {2'b00, cnt_q[2:0] + 3'd1};
               if (cnt_q[2:0] == 3'd0) begin
                  obuf_d = pbuf_q;
                  miso_d = pbuf_q[7];
                  if (state_q == ST_DATA) begin
                     rd_d    = 1'b1;
                     maddr_d = addr_q[ADDR_WIDTH-1:0];
                  end
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
                  else begin
                     pbuf_d = id_byte;
                     idx_d  = (idx_q == 2'd3) ? 2'd3 : idx_q + 2'd1;
                  end
`endif
               end else begin
                  obuf_d = obuf_q << 1;
                  miso_d = obuf_q[6];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sck_q    <= '0;
         cs_q     <= '0;
         mosi_q   <= '0;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         addr_q   <= '0;
         pbuf_q   <= '0;
         obuf_q   <= '0;
         miso_q   <= 1'b1;
         rd_q     <= 1'b0;
         rd_dly_q <= 1'b0;
         maddr_q  <= '0;
         armed_q  <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
         idx_q    <= '0;
`endif
      end else begin
         sck_q    <= {sck_q[1:0], flash_sck};
         cs_q     <= {cs_q[0], flash_cs_n};
         mosi_q   <= {mosi_q[0], flash_mosi};
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         addr_q   <= addr_d;
         pbuf_q   <= pbuf_d;
         obuf_q   <= obuf_d;
         miso_q   <= miso_d;
         rd_q     <= rd_d;
         rd_dly_q <= rd_q;
         maddr_q  <= maddr_d;
         armed_q  <= armed_d;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
         idx_q    <= idx_d;
`endif
      end
   end

`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
   assign flash_miso_oe = (state_q == ST_DATA) || (state_q == ST_ID);
`else
   assign flash_miso_oe = (state_q == ST_DATA);
`endif
   assign flash_miso = flash_miso_oe ? miso_q : 1'b1;
   assign mem_addr   = maddr_q;
   assign mem_rd     = rd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed + randomized bench for spi_flash_responder. A byte memory whose
// content is (address low byte XOR seed) serves reads; expectations are
// computed from the READ protocol rules (start address, auto-increment,
// 24-bit wrap, ADDR_WIDTH truncation).
module tb_spi_flash_responder;
   localparam int AW = 19;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
   logic          miso, oe, mem_rd;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata = 8'h00;
   logic [7:0]    seed = 8'h00;

   int checks = 0, errors = 0;
   // Monitor-owned statistics (written only by the monitor process).
   int rdcnt = 0, oecnt = 0, consec = 0, rel_bad = 0;
   logic rd_prev = 1'b0;
   logic mon_en = 1'b0;
   logic [AW-1:0] addrq[$];

   spi_flash_responder #(.ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset), .flash_sck(sck), .flash_cs_n(cs_n),
      .flash_mosi(mosi), .flash_miso(miso), .flash_miso_oe(oe),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata));

   always #5 clock = ~clock;

   always @(posedge clock) if (mem_rd) mem_rdata <= mem_addr[7:0] ^ seed;

   always @(negedge clock) if (mon_en) begin
      if (mem_rd) begin
         addrq.push_back(mem_addr);
         rdcnt++;
         if (rd_prev) consec++;
      end
      rd_prev = mem_rd;
      if (oe) oecnt++;
      else if (miso !== 1'b1) rel_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Shift n bits MSB first; MISO sampled just before each rise. With
   // keep_high the final SCK fall is deferred (done by end_txn after CS#).
   task automatic spi_bits(input int n, input logic [31:0] v, input bit keep_high,
                           output logic [31:0] r);
      r = 0;
      for (int i = n - 1; i >= 0; i--) begin
         mosi = v[i];
         #80;
         r = {r[30:0], miso};
         sck = 1'b1;
         #80;
         if (i != 0 || !keep_high) sck = 1'b0;
      end
   endtask

   task automatic begin_txn();
      cs_n = 1'b0;
      #80;
   endtask

   task automatic end_txn();
      cs_n = 1'b1;
      #80;
      sck = 1'b0;
      #200;
   endtask

   // Full READ transaction checked against the address/data model.
   task automatic read_txn(input string tag, input logic [23:0] a, input int n);
      logic [31:0] r;
      int rd0, q0, oe_mid;
      logic [23:0] ea;
      rd0 = rdcnt; q0 = addrq.size(); oe_mid = 0;
      begin_txn();
      spi_bits(8, 32'h03, 1'b0, r);
      spi_bits(24, {8'h00, a}, 1'b0, r);
      for (int i = 0; i < n; i++) begin
         spi_bits(8, 32'($urandom_range(255)), (i == n - 1), r);
         ea = a + 24'(i);
         chk({tag, "_byte"}, r, 32'(ea[7:0] ^ seed));
         if (i == 0) oe_mid = int'(oe);
      end
      chk({tag, "_oe"}, 32'(oe_mid), 32'd1);
      end_txn();
      chk({tag, "_oe_idle"}, 32'(oe), 32'd0);
      chk({tag, "_rdcnt"}, 32'(rdcnt - rd0), 32'(n + 1));
      for (int i = 0; i <= n && q0 + i < addrq.size(); i++) begin
         ea = a + 24'(i);
         chk({tag, "_addr"}, 32'(addrq[q0 + i]), 32'(ea[AW-1:0]));
      end
   endtask

   initial begin
      logic [31:0] r;
      int rd0, oe0;
      // Reset state.
      repeat (3) @(negedge clock);
      chk("rst_miso", 32'(miso), 32'd1);
      chk("rst_oe", 32'(oe), 32'd0);
      chk("rst_rd", 32'(mem_rd), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;
      mon_en = 1'b1;
      #202;

      // Directed READ at 0x10 with identity memory.
      seed = 8'h00;
      read_txn("rd10", 24'h000010, 3);
      // Address wrap at 24 bits / ADDR_WIDTH.
      seed = 8'h00;
      read_txn("wrap", 24'hFFFFFF, 2);

      // Abort after 12 address bits.
      rd0 = rdcnt;
      begin_txn();
      spi_bits(8, 32'h03, 1'b0, r);
      spi_bits(12, 32'($urandom_range(4095)), 1'b1, r);
      cs_n = 1'b1;
      #40;
      chk("abort_oe", 32'(oe), 32'd0);
      end_txn();
      chk("abort_rd", 32'(rdcnt - rd0), 32'd0);

      // Unknown command 0x05 followed by 16 SCKs.
      rd0 = rdcnt; oe0 = oecnt;
      begin_txn();
      spi_bits(8, 32'h05, 1'b0, r);
      spi_bits(16, 32'($urandom_range(65535)), 1'b1, r);
      end_txn();
      chk("ign_oe", 32'(oecnt - oe0), 32'd0);
      chk("ign_rd", 32'(rdcnt - rd0), 32'd0);
      seed = 8'($urandom_range(255));
      read_txn("after_ign", 24'($urandom), 2);

      // JEDEC ID command.
      rd0 = rdcnt; oe0 = oecnt;
      begin_txn();
      spi_bits(8, 32'h9F, 1'b0, r);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] idexp;
         logic [31:0] id;
         id = 32'hEF4015FF;
         spi_bits(8, 32'h00, (i == 3), r);
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
         idexp = 32'(id[31 - 8*i -: 8]);
`else
         idexp = 32'hFF;
`endif
         chk("jedec_byte", r, idexp);
      end
      end_txn();
      chk("jedec_rd", 32'(rdcnt - rd0), 32'd0);
`ifndef SPI_FLASH_RESPONDER_JEDEC_EN
      chk("jedec_oe", 32'(oecnt - oe0), 32'd0);
`endif

      // Reset pulsed during byte 2 of a READ; CS# stays low.
      seed = 8'($urandom_range(255));
      begin_txn();
      spi_bits(8, 32'h03, 1'b0, r);
      spi_bits(24, 32'($urandom), 1'b0, r);
      spi_bits(8, 32'h00, 1'b0, r);
      spi_bits(4, 32'h0, 1'b1, r);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_miso", 32'(miso), 32'd1);
      chk("midrst_oe", 32'(oe), 32'd0);
      chk("midrst_rd", 32'(mem_rd), 32'd0);
      chk("midrst_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;
      rd0 = rdcnt; oe0 = oecnt;
      sck = 1'b0;
      spi_bits(12, 32'($urandom_range(4095)), 1'b1, r);
      end_txn();
      chk("postrst_rd", 32'(rdcnt - rd0), 32'd0);
      chk("postrst_oe", 32'(oecnt - oe0), 32'd0);
      read_txn("postrst", 24'($urandom), 2);

      // Randomized READs.
      for (int t = 0; t < 4; t++) begin
         seed = 8'($urandom_range(255));
         read_txn("rand", 24'($urandom), int'($urandom_range(4, 1)));
      end

      chk("rd_back2back", 32'(consec), 32'd0);
      chk("miso_released", 32'(rel_bad), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
